// File: rtl/ddr4_pll_pkg.sv
// Shared types and constants for the DDR4 PLL phase-shift controller.
package ddr4_pll_pkg;

  typedef enum logic [2:0] {
    ST_PWRDN,
    ST_WAIT_LOCK,
    ST_IDLE,
    ST_SETUP,
    ST_ROT_HI,
    ST_ROT_LO,
    ST_LOAD,
    ST_DONE
  } pll_state_t;

  localparam logic [1:0] SEL_OUT0 = 2'd0;
  localparam logic [1:0] SEL_OUT2 = 2'd2;
  localparam logic [1:0] SEL_OUT3 = 2'd3;

  localparam int unsigned STEPS_W = 8;
  localparam int unsigned POS_W   = 9;
  localparam int unsigned CNT_W   = 16;

  function automatic logic sel_legal(input logic [1:0] sel);
    return (sel == SEL_OUT0) || (sel == SEL_OUT2) || (sel == SEL_OUT3);
  endfunction

endpackage

// File: rtl/ddr4_pll_lock_sync.sv
// Two-flop synchronizer bringing the raw PLL lock into the controller clock domain.
module ddr4_pll_lock_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic lock_raw,
  output logic lock_sync
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta      <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      meta      <= lock_raw;
      lock_sync <= meta;
    end
  end

endmodule

// File: rtl/ddr4_pll_phase_ctrl.sv
// DDR4 PLL power-up/lock sequencing and phase-rotation request controller.
// Optional per-output phase position tracking: define DDR4_PLL_PHASE_TRACK_EN.
module ddr4_pll_phase_ctrl
  import ddr4_pll_pkg::*;
#(
  parameter int unsigned PD_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned ROT_GAP      = 4
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      PLL_LOCK_0,
  input  logic                      REQ_VALID,
  output logic                      REQ_READY,
  input  logic [1:0]                REQ_OUT_SEL,
  input  logic                      REQ_DIR,
  input  logic [STEPS_W-1:0]        REQ_STEPS,
  output logic                      REQ_DONE,
  output logic                      REQ_ERR,
  output logic                      PLL_POWERDOWN_N_0,
  output logic                      PHASE_OUT0_SEL_0,
  output logic                      PHASE_OUT2_SEL_0,
  output logic                      PHASE_OUT3_SEL_0,
  output logic                      PHASE_DIRECTION_0,
  output logic                      PHASE_ROTATE_0,
  output logic                      LOAD_PHASE_N_0,
  output logic                      PLL_READY,
  output logic                      LOCK_LOST,
  output logic signed [POS_W-1:0]   PHASE_POS0,
  output logic signed [POS_W-1:0]   PHASE_POS2,
  output logic signed [POS_W-1:0]   PHASE_POS3
);

  localparam logic [CNT_W-1:0] PD_LAST  = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(ROT_GAP - 1);

  pll_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [STEPS_W-1:0] steps_left;
  logic [1:0]         req_sel;
  logic               req_dir, req_err;
  logic               lock_s, lock_lost;
  logic               active, abort, ready, accept, req_illegal, done_pulse, sel_on;

  ddr4_pll_lock_sync u_lock_sync (
    .clk       (CLK),
    .reset_n   (RESET_N),
    .lock_raw  (PLL_LOCK_0),
    .lock_sync (lock_s)
  );

  assign active      = state inside {ST_IDLE, ST_SETUP, ST_ROT_HI, ST_ROT_LO, ST_LOAD, ST_DONE};
  assign abort       = active && !lock_s;
  assign ready       = (state == ST_IDLE) && lock_s;
  assign accept      = ready && REQ_VALID;
  assign req_illegal = !sel_legal(REQ_OUT_SEL) || (REQ_STEPS == '0);
  // Gated by lock_s so a request aborted in its final cycle reports no completion.
  assign done_pulse  = (state == ST_DONE) && lock_s;

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= ST_PWRDN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_PWRDN:     if (cnt == PD_LAST) state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s)              state_nxt = ST_IDLE;
        else if (cnt == TO_LAST) state_nxt = ST_PWRDN;
      end
      ST_IDLE:      if (accept) state_nxt = req_illegal ? ST_DONE : ST_SETUP;
      ST_SETUP:     state_nxt = ST_ROT_HI;
      ST_ROT_HI:    if (cnt == GAP_LAST) state_nxt = ST_ROT_LO;
      ST_ROT_LO: begin
        if (cnt == GAP_LAST)
          state_nxt = (steps_left == STEPS_W'(1)) ? ST_LOAD : ST_ROT_HI;
      end
      ST_LOAD:      state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_PWRDN;
    endcase
    if (abort) state_nxt = ST_WAIT_LOCK;
  end

  always_comb begin
    sel_on            = state inside {ST_SETUP, ST_ROT_HI, ST_ROT_LO, ST_LOAD};
    PLL_POWERDOWN_N_0 = (state != ST_PWRDN);
    PHASE_ROTATE_0    = (state == ST_ROT_HI);
    LOAD_PHASE_N_0    = (state != ST_LOAD);
    PHASE_OUT0_SEL_0  = sel_on && (req_sel == SEL_OUT0);
    PHASE_OUT2_SEL_0  = sel_on && (req_sel == SEL_OUT2);
    PHASE_OUT3_SEL_0  = sel_on && (req_sel == SEL_OUT3);
    PHASE_DIRECTION_0 = sel_on && req_dir;
    REQ_READY         = ready;
    REQ_DONE          = done_pulse;
    REQ_ERR           = done_pulse && req_err;
    PLL_READY         = active && lock_s;
    LOCK_LOST         = lock_lost;
  end

  // Phase counter restarts on every state change, including ROT_LO -> ROT_HI.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt        <= '0;
      steps_left <= '0;
      req_sel    <= '0;
      req_dir    <= 1'b0;
      req_err    <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      cnt <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      if (accept) begin
        req_sel    <= REQ_OUT_SEL;
        req_dir    <= REQ_DIR;
        req_err    <= req_illegal;
        steps_left <= REQ_STEPS;
      end else if ((state == ST_ROT_LO) && (cnt == GAP_LAST)) begin
        steps_left <= steps_left - STEPS_W'(1);
      end
      if (abort) lock_lost <= 1'b1;
    end
  end

`ifdef DDR4_PLL_PHASE_TRACK_EN
  logic [STEPS_W-1:0]      req_steps;
  logic signed [POS_W-1:0] pos0, pos2, pos3, delta;

  assign delta = req_dir ? $signed({1'b0, req_steps}) : -$signed({1'b0, req_steps});

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      req_steps <= '0;
      pos0      <= '0;
      pos2      <= '0;
      pos3      <= '0;
    end else begin
      if (accept) req_steps <= REQ_STEPS;
      if (done_pulse && !req_err) begin
        case (req_sel)
          SEL_OUT0: pos0 <= pos0 + delta;
          SEL_OUT2: pos2 <= pos2 + delta;
          SEL_OUT3: pos3 <= pos3 + delta;
          default:  ;
        endcase
      end
    end
  end

  assign PHASE_POS0 = pos0;
  assign PHASE_POS2 = pos2;
  assign PHASE_POS3 = pos3;
`else
  assign PHASE_POS0 = '0;
  assign PHASE_POS2 = '0;
  assign PHASE_POS3 = '0;
`endif

endmodule

// File: doc/ddr4_pll_phase_ctrl.md
DDR4_PLL_PHASE_CTRL -- requirements
Module: ddr4_pll_phase_ctrl

Interface
REQ-001 Parameter PD_CYCLES, default 16: PLL_POWERDOWN_N_0 low time after reset or retry, in CLK cycles (range 2..255).
REQ-002 Parameter LOCK_TIMEOUT, default 4096: CLK cycles allowed for lock before a retry (range 16..65535).
REQ-003 Parameter ROT_GAP, default 4: CLK cycles PHASE_ROTATE_0 is high, and then low, per step (range 1..15).
REQ-004 Clocking: one clock; reset is synchronous and active-low. Ports CLK (in, 1, controller clock) and RESET_N (in, 1, synchronous active-low reset).
REQ-005 PLL_LOCK_0  in  1  raw PLL lock, asynchronous to CLK.
REQ-006 REQ_VALID  in  1  phase-shift request valid.
REQ-007 REQ_READY  out  1  request accepted when REQ_VALID and REQ_READY are both high.
REQ-008 REQ_OUT_SEL  in  2  target output: 0=OUT0, 2=OUT2, 3=OUT3; 1 is illegal.
REQ-009 REQ_DIR  in  1  1=advance, 0=retard.
REQ-010 REQ_STEPS  in  8  number of rotate steps, 1..255; 0 is illegal.
REQ-011 REQ_DONE  out  1  one-cycle pulse when a request completes or is rejected.
REQ-012 REQ_ERR  out  1  valid with REQ_DONE: 1=illegal request, not executed.
REQ-013 PLL_POWERDOWN_N_0  out  1  PLL power-down, active-low.
REQ-014 PHASE_OUT0_SEL_0, PHASE_OUT2_SEL_0, PHASE_OUT3_SEL_0  out  1 each  one-hot output select for rotation.
REQ-015 PHASE_DIRECTION_0, PHASE_ROTATE_0, LOAD_PHASE_N_0  out  1 each  PLL phase controls.
REQ-016 PLL_READY  out  1  synchronized lock, and the controller is in IDLE or executing a request.
REQ-017 LOCK_LOST  out  1  sticky flag set on loss of lock while ready; cleared only by reset.
REQ-018 PHASE_POS0, PHASE_POS2, PHASE_POS3  out  9 each  signed net step count per output.

Function
REQ-019 PLL_LOCK_0 passes through a 2-flop synchronizer; only the synchronized value (lock_s) is used internally.
REQ-020 States: PWRDN, WAIT_LOCK, IDLE, SETUP, ROT_HI, ROT_LO, LOAD, DONE.
REQ-021 PWRDN: PLL_POWERDOWN_N_0=0 for exactly PD_CYCLES cycles, then go to WAIT_LOCK with PLL_POWERDOWN_N_0=1.
REQ-022 WAIT_LOCK: if lock_s=1, go to IDLE; if LOCK_TIMEOUT cycles elapse without lock, go to PWRDN (retry forever).
REQ-023 IDLE: REQ_READY=1 only in IDLE with lock_s=1; acceptance latches SEL, DIR and STEPS.
REQ-024 Illegal request (SEL=1 or STEPS=0): go IDLE -> DONE with no PLL activity, then pulse REQ_DONE with REQ_ERR=1 one cycle later.
REQ-025 SETUP: lasts one cycle; drive the selected PHASE_OUTx_SEL high, the others low, and PHASE_DIRECTION_0=DIR; go to ROT_HI.
REQ-026 ROT_HI: PHASE_ROTATE_0=1 for ROT_GAP cycles. ROT_LO: PHASE_ROTATE_0=0 for ROT_GAP cycles, then decrement the step counter; go to ROT_HI while steps remain, else to LOAD.
REQ-027 LOAD: LOAD_PHASE_N_0=0 for exactly one cycle; go to DONE.
REQ-028 DONE: REQ_DONE=1 and REQ_ERR=0 for one cycle; clear SEL outputs; return to IDLE.
REQ-029 Execution latency from accept to REQ_DONE = 1 + 2*ROT_GAP*STEPS + 2 cycles.
REQ-030 PHASE_OUTx_SEL and PHASE_DIRECTION_0 stay stable from SETUP through LOAD.
REQ-031 lock_s falling in IDLE or in any request state: set LOCK_LOST, abort immediately, drive PHASE_ROTATE_0=0 and LOAD_PHASE_N_0=1, go to WAIT_LOCK; no REQ_DONE for the aborted request.
REQ-032 A new request is accepted no earlier than the cycle after REQ_DONE.

Reset
REQ-033 While RESET_N=0 at a CLK edge: state=PWRDN with counters cleared, PLL_POWERDOWN_N_0=0, LOAD_PHASE_N_0=1, all other outputs 0, PHASE_POS*=0.
REQ-034 Reset asserted mid-request abandons the request with no REQ_DONE.

Configuration
REQ-035 Macro DDR4_PLL_PHASE_TRACK_EN defined: each completed legal request adds +STEPS (advance) or -STEPS (retard) to its PHASE_POSx, wrapping two's-complement at 9 bits; aborted requests leave PHASE_POSx unchanged.
REQ-036 Macro not defined: PHASE_POS* ports remain present and are tied to 0; no accumulator logic is built.

Structure
REQ-037 Shared package ddr4_pll_pkg holds: state enum, output-select encodings (0, 2, 3), and the widths of STEPS and POS.
REQ-038 A single sub-module, ddr4_pll_lock_sync (2-flop synchronizer), is instantiated.

Verification
REQ-039 Reset release with lock high at cycle 30 (PD_CYCLES=16) -> POWERDOWN_N rises at cycle 16, PLL_READY=1 by cycle 33.
REQ-040 Lock held low (LOCK_TIMEOUT=64) -> PWRDN re-entered every 16+64 cycles, REQ_READY stays 0.
REQ-041 Request SEL=2, DIR=1, STEPS=3, ROT_GAP=4 -> 3 rotate pulses of 4 cycles, one LOAD_PHASE_N_0 low cycle, REQ_DONE 27 cycles after accept, PHASE_POS2=+3 (macro on).
REQ-042 Request SEL=1 or STEPS=0 -> REQ_DONE with REQ_ERR=1, no rotate or load activity.
REQ-043 Lock drops during ROT_HI of step 2 -> PHASE_ROTATE_0=0 next cycle, LOCK_LOST=1, no REQ_DONE, PHASE_POS unchanged.
REQ-044 Two back-to-back SEL=0 requests (DIR=0, STEPS=200 each) -> PHASE_POS0 wraps to +112; without macro, PHASE_POS0=0.
